// File: rtl/vp_pkg.sv
// Shared opcode encodings and default geometry for the vertex lane pipeline.
package vp_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 32;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_DOT  = 3'd7;

endpackage

// File: rtl/vp_lane_alu.sv
// Combinational single-lane ALU; DOT produces the lane product, reduction happens downstream.
module vp_lane_alu
    import vp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = 3
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res
);

    // Per-lane operation select, all results modulo 2^DATA_W.
    always_comb begin
        res = '0;
        case (op)
            OP_W'(OP_ADD):  res = a + b;
            OP_W'(OP_SUB):  res = a - b;
            OP_W'(OP_MUL):  res = a * b;
            OP_W'(OP_AND):  res = a & b;
            OP_W'(OP_OR):   res = a | b;
            OP_W'(OP_XOR):  res = a ^ b;
            OP_W'(OP_PASS): res = a;
            OP_W'(OP_DOT):  res = a * b;
            default:        res = '0;
        endcase
    end

endmodule

// File: rtl/vertex_lane_pipe.sv
// Three-stage vector lane pipeline (operand reg, lane ALU, reduce/output) with global output stall.
// Define VERTEX_LANE_PIPE_REDUCE_EN to build the DOT reduction; otherwise opcode 7 is lane-wise MUL.
module vertex_lane_pipe
    import vp_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_op,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [15:0]             out_count
);

    localparam int VW = LANES * DATA_W;

    logic            s1_valid_r;
    logic [OP_W-1:0] s1_op_r;
    logic [VW-1:0]   s1_a_r;
    logic [VW-1:0]   s1_b_r;
    logic            s2_valid_r;
    logic [VW-1:0]   s2_res_r;
    logic            out_valid_r;
    logic [VW-1:0]   out_data_r;
    logic [15:0]     out_count_r;

    logic            stall_s;
    logic            advance_s;
    logic            in_xfer_s;
    logic            out_xfer_s;
    logic [VW-1:0]   alu_res_s;
    logic [VW-1:0]   reduce_s;

`ifdef VERTEX_LANE_PIPE_REDUCE_EN
    logic              s2_dot_r;
    logic [DATA_W-1:0] dot_sum_s;
`endif

    // Every stage moves together, so bubbles are filled whenever the output is not blocked.
    assign stall_s    = out_valid_r && !out_ready;
    assign advance_s  = enable && !stall_s;
    assign in_ready   = advance_s;
    assign in_xfer_s  = in_valid && advance_s;
    assign out_xfer_s = enable && out_valid_r && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vp_lane_alu #(
            .DATA_W (DATA_W),
            .OP_W   (OP_W)
        ) u_alu (
            .op  (s1_op_r),
            .a   (s1_a_r[i*DATA_W +: DATA_W]),
            .b   (s1_b_r[i*DATA_W +: DATA_W]),
            .res (alu_res_s[i*DATA_W +: DATA_W])
        );
    end

    // Output-stage shaping: DOT collapses lane products into lane 0.
    always_comb begin
        reduce_s = s2_res_r;
`ifdef VERTEX_LANE_PIPE_REDUCE_EN
        dot_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_sum_s = dot_sum_s + s2_res_r[i*DATA_W +: DATA_W];
        end
        if (s2_dot_r) begin
            reduce_s               = '0;
            reduce_s[DATA_W-1:0]   = dot_sum_s;
        end else begin
            reduce_s = s2_res_r;
        end
`endif
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_op_r     <= '0;
            s1_a_r      <= '0;
            s1_b_r      <= '0;
            s2_valid_r  <= 1'b0;
            s2_res_r    <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= 16'd0;
        end else if (advance_s) begin
            s1_valid_r  <= in_xfer_s;
            if (in_xfer_s) begin
                s1_op_r <= in_op;
                s1_a_r  <= in_a;
                s1_b_r  <= in_b;
            end
            s2_valid_r  <= s1_valid_r;
            if (s1_valid_r) begin
                s2_res_r <= alu_res_s;
            end
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_data_r <= reduce_s;
            end
            if (out_xfer_s) begin
                out_count_r <= out_count_r + 16'd1;
            end
        end
    end

`ifdef VERTEX_LANE_PIPE_REDUCE_EN
    // DOT marker travels alongside the S2 lane results.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_dot_r <= 1'b0;
        end else if (advance_s && s1_valid_r) begin
            s2_dot_r <= (s1_op_r == OP_W'(OP_DOT));
        end
    end
`endif

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;

endmodule

// File: tb/tb_vertex_lane_pipe.sv
// Self-checking bench: directed corner cases plus randomized traffic against a queue-based reference model.
module tb_vertex_lane_pipe;

    localparam int VW = 128;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [VW-1:0] in_a;
    logic [VW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [15:0]   out_count;

    typedef struct {
        logic [VW-1:0] res;
        int            pos;
    } item_t;

    item_t       q[$];
    logic [15:0] m_count;
    int          checks;
    int          errors;

    vertex_lane_pipe #(.LANES(4), .DATA_W(32), .OP_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain per-lane arithmetic on 32-bit lanes.
    function automatic logic [VW-1:0] ref_vec(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        logic [31:0]   x, y, acc;
        r   = '0;
        acc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            x = a[i*32 +: 32];
            y = b[i*32 +: 32];
            case (op)
                3'd0: r[i*32 +: 32] = x + y;
                3'd1: r[i*32 +: 32] = x - y;
                3'd2: r[i*32 +: 32] = x * y;
                3'd3: r[i*32 +: 32] = x & y;
                3'd4: r[i*32 +: 32] = x | y;
                3'd5: r[i*32 +: 32] = x ^ y;
                3'd6: r[i*32 +: 32] = x;
`ifdef VERTEX_LANE_PIPE_REDUCE_EN
                3'd7: acc = acc + x * y;
`else
                3'd7: r[i*32 +: 32] = x * y;
`endif
                default: r[i*32 +: 32] = 32'd0;
            endcase
        end
`ifdef VERTEX_LANE_PIPE_REDUCE_EN
        if (op == 3'd7) r[31:0] = acc;
`endif
        return r;
    endfunction

    // One cycle: drive at negedge, check against model, advance model as the coming posedge will.
    task automatic step(input logic en, input logic iv, input logic ordy, input logic [2:0] op,
                        input logic [VW-1:0] a, input logic [VW-1:0] b, output logic acc);
        logic mv, adv;
        enable = en; in_valid = iv; out_ready = ordy; in_op = op; in_a = a; in_b = b;
        #1;
        mv  = (q.size() > 0) && (q[0].pos == 3);
        adv = en && !(mv && !ordy);
        chk("in_ready", in_ready, adv);
        chk("out_valid", out_valid, mv);
        if (mv) chk("out_data", out_data, q[0].res);
        chk("out_count", out_count, m_count);
        acc = iv && adv;
        if (adv) begin
            if (mv) begin
                void'(q.pop_front());
                m_count++;
            end
            foreach (q[i]) q[i].pos++;
            if (acc) q.push_back('{ref_vec(op, a, b), 1});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b1, 1'b0, ordy, 3'd0, '0, '0, acc);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'($urandom); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        q.delete();
        m_count = 16'd0;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", out_count, 16'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    // Issue into an empty pipe and check the fixed-constant result three cycles later.
    task automatic issue_expect(input string tag, input logic [2:0] op, input logic [VW-1:0] a,
                                input logic [VW-1:0] b, input logic [VW-1:0] expv);
        logic acc;
        step(1'b1, 1'b1, 1'b1, op, a, b, acc);
        chk({tag, "_acc"}, acc, 1'b1);
        idle(1'b1);
        idle(1'b1);
        #1;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk(tag, out_data, expv);
        idle(1'b1);
    endtask

    initial begin
        logic          acc;
        logic [VW-1:0] va, vb, dot_exp;
        logic [15:0]   cnt0;
        int            k, guard;
        checks = 0; errors = 0; m_count = 16'd0;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_a = '0; in_b = '0;
        do_reset();

        issue_expect("add_vec", 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
                     {32'd44, 32'd33, 32'd22, 32'd11});
        #1 chk("add_count", out_count, 16'd1);
`ifdef VERTEX_LANE_PIPE_REDUCE_EN
        dot_exp = {32'd0, 32'd0, 32'd0, 32'd70};
`else
        dot_exp = {32'd32, 32'd21, 32'd12, 32'd5};
`endif
        issue_expect("dot_vec", 3'd7, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, dot_exp);
        issue_expect("sub_wrap", 3'd1, '0, {32'd1, 32'd1, 32'd1, 32'd1}, {4{32'hFFFF_FFFF}});
        issue_expect("mul_wrap", 3'd2, {4{32'hFFFF_FFFF}}, {4{32'd2}}, {4{32'hFFFF_FFFE}});
        drain();

        // Five back-to-back SUBs, consumer stalls in cycles 4..6.
        cnt0 = m_count;
        k = 0;
        for (int c = 0; c < 30 && q.size() + k >= 0; c++) begin
            logic ordy;
            ordy = !(c >= 4 && c <= 6);
            va = {$urandom, $urandom, $urandom, $urandom};
            vb = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, k < 5, ordy, 3'd1, va, vb, acc);
            if (c >= 4 && c <= 6) chk("stall_in_ready", acc, 1'b0);
            if (acc) k++;
            if (k == 5 && q.size() == 0) break;
        end
        chk("sub5_delivered", 16'(m_count - cnt0), 16'd5);
        #1 chk("sub5_count", out_count, 16'(cnt0 + 16'd5));
        drain();

        // Enable low for four cycles with work in flight.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b1, 3'd5, {4{$urandom}}, {4{$urandom}}, acc);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 1'b1, 3'd0, {4{$urandom}}, {4{$urandom}}, acc);
            chk("en_low_accept", acc, 1'b0);
        end
        drain();

        // Reset with three ops in flight and the consumer blocked.
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 3'd0, {4{$urandom}}, {4{$urandom}}, acc);
        do_reset();
        for (int c = 0; c < 4; c++) idle(1'b1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            va = {$urandom, $urandom, $urandom, $urandom};
            vb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                va = va & {4{32'h0000_00FF}};
                vb = vb & {4{32'h0000_00FF}};
            end
            step($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), va, vb, acc);
        end
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            idle(1'b1);
            guard++;
        end
        chk("final_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vertex_lane_pipe.md
VERTEX_LANE_PIPE -- requirements
Module: vertex_lane_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel vector lanes (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, width of one lane element.
REQ-003 SHALL have parameter OP_W, default 3, opcode width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  when low, all pipeline state holds and in_ready=0.
REQ-007 SHALL have port in_valid  input  1  an input operation is offered.
REQ-008 SHALL have port in_ready  output  1  the pipeline accepts the offered operation.
REQ-009 SHALL have port in_op  input  OP_W  opcode.
REQ-010 SHALL have port in_a  input  LANES*DATA_W  operand A; lane i is bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port in_b  input  LANES*DATA_W  operand B, same lane packing.
REQ-012 SHALL have port out_valid  output  1  out_data holds a result.
REQ-013 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-014 SHALL have port out_data  output  LANES*DATA_W  result vector.
REQ-015 SHALL have port out_count  output  16  count of results delivered since reset.

Function
REQ-016 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready, both on the rising clk edge.
REQ-017 SHALL implement a 3-stage pipeline (S1 operand register, S2 lane ALU, S3 reduce/output); latency SHALL be exactly 3 cycles from input transfer to out_valid when never stalled.
REQ-018 SHALL sustain one transfer per cycle when out_ready=1 and enable=1.
REQ-019 SHALL apply these opcodes per lane, modulo 2^DATA_W: 0 ADD a+b, 1 SUB a-b, 2 MUL low DATA_W bits of a*b, 3 AND, 4 OR, 5 XOR, 6 PASS a.
REQ-020 SHALL implement opcode 7 DOT: sum of all lane products modulo 2^DATA_W in lane 0, other lanes zero.
REQ-021 SHALL stall S1..S3 together when out_valid && !out_ready; in_ready SHALL be 0 during the stall and no stage SHALL lose or duplicate data.
REQ-022 SHALL drive in_ready = enable && !(out_valid && !out_ready), registered-free (combinational from the current state).
REQ-023 SHALL advance bubbles: an empty stage SHALL be filled even while a later stage holds data, provided the output is not stalled.
REQ-024 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL increment out_count on each output transfer, wrapping 16'hFFFF -> 0.
REQ-026 SHALL, with enable=0, freeze all valid bits, data and out_count; out_valid keeps its value, but no output transfer occurs even if out_ready=1.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, clear all stage valid bits, out_valid=0, out_data=0, out_count=0, regardless of enable or stall; in-flight operations are discarded.
REQ-028 SHALL take reset precedence over simultaneous input/output transfers.

Configuration
REQ-029 SHALL compile the DOT reduction adder tree only when macro VERTEX_LANE_PIPE_REDUCE_EN is defined.
REQ-030 SHALL, without VERTEX_LANE_PIPE_REDUCE_EN, treat opcode 7 as lane-wise MUL (opcode 2) with identical latency.

Structure
REQ-031 SHALL place opcode localparams (OP_ADD..OP_DOT) and default LANES/DATA_W in shared package vp_pkg.
REQ-032 SHALL instantiate sub-module vp_lane_alu (one per lane, combinational, DATA_W-parametrised) inside S2.

Verification
REQ-033 SHALL cover: LANES=4, ADD a={1,2,3,4}, b={10,20,30,40}, out_ready=1 -> out_data={11,22,33,44} exactly 3 cycles later, out_count=1.
REQ-034 SHALL cover: DOT a={1,2,3,4}, b={5,6,7,8} -> lane0=70, lanes1..3=0 with macro; {5,12,21,32} without.
REQ-035 SHALL cover: 5 back-to-back SUB ops, out_ready low cycles 4-6 -> in_ready low those cycles, 5 results in order, none lost or duplicated.
REQ-036 SHALL cover: SUB 0-1 and MUL 32'hFFFF_FFFF*2 -> 32'hFFFF_FFFF and 32'hFFFF_FFFE.
REQ-037 SHALL cover: reset asserted with 3 ops in flight and out_ready=0 -> next cycle out_valid=0, out_count=0, no stale results afterward.
REQ-038 SHALL cover: enable=0 for 4 cycles mid-stream -> in_ready=0, state frozen, stream resumes unchanged.
